// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl : EXE-stage multiply/divide sequencer
//
// Launches one operation per EXE instruction onto either the fixed-latency
// pipelined multiplier IP or the variable-latency AXI-stream divider IP.
// It counts multiplier latency, waits for the divider's tvalid, and latches
// HI/LO. The latched result is held until MEM accepts it. A flush while a
// divide is in flight drains the divider so that a stale result is never
// mistaken for a later one.
//
// Parameters
//   MULT_LAT : multiplier IP latency in cycles (1..31)
//   DIV_MAX  : divider watchdog limit in cycles; reaching it sets div_timeout
//
// Optional feature (compile-time macro MD_DIV_ZERO_BYPASS_EN)
//   When defined, a divide with src2 == 0 never reaches the divider. The
//   result is hi = src1, lo = 32'hFFFFFFFF, and it is ready the cycle after
//   start. When undefined, divide-by-zero goes through the divider normally.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   exe_valid            : EXE holds a valid instruction
//   op_mul / op_div      : instruction class (never both set)
//   op_unsigned          : unsigned variant
//   src1, src2           : operands; held stable by EXE while md_busy
//   cancel               : flush of the EXE instruction
//   next_allow           : MEM accepts the EXE result this cycle
//   mult_a, mult_b       : 33-bit sign/zero-extended multiplier operands
//   mult_p               : multiplier product
//   div_dividend/divisor : 33-bit sign/zero-extended divider operands
//   div_in_valid         : one-cycle operand tvalid pulse to the divider
//   div_out_valid/data   : divider result tvalid / tdata
//   md_over              : result held and stable; EXE may complete
//   md_busy              : controller not idle
//   hi_result, lo_result : HI / LO values
//   div_timeout          : sticky divider watchdog flag
// -----------------------------------------------------------------------------
module md_ctrl #(
    parameter int MULT_LAT = 1,
    parameter int DIV_MAX  = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_valid,
    input  logic        op_mul,
    input  logic        op_div,
    input  logic        op_unsigned,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    input  logic        next_allow,
    output logic [32:0] mult_a,
    output logic [32:0] mult_b,
    input  logic [65:0] mult_p,
    output logic [32:0] div_dividend,
    output logic [32:0] div_divisor,
    output logic        div_in_valid,
    input  logic        div_out_valid,
    input  logic [79:0] div_out_data,
    output logic        md_over,
    output logic        md_busy,
    output logic [31:0] hi_result,
    output logic [31:0] lo_result,
    output logic        div_timeout
);

    // One counter is shared by the multiplier latency count and the divider
    // watchdog, so it must be wide enough for the larger of the two.
    localparam int CNT_MAX = (DIV_MAX > MULT_LAT) ? DIV_MAX : MULT_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_WAIT  = 3'd1,
        DIV_ISSUE = 3'd2,
        DIV_WAIT  = 3'd3,
        DONE      = 3'd4,
        DRAIN     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               timeout_q, timeout_d;
    logic               start;
    logic               div_zero_bypass;
    logic               unused_bits;

    // Extend a 32-bit operand to 33 bits so the IPs can treat both signed and
    // unsigned variants as signed arithmetic.
    function automatic logic [32:0] ext33(input logic [31:0] v, input logic uns);
        return {(uns ? 1'b0 : v[31]), v};
    endfunction

    // Saturating increment: a stuck divider must not wrap the watchdog count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mult_a       = ext33(src1, op_unsigned);
    assign mult_b       = ext33(src2, op_unsigned);
    assign div_dividend = ext33(src1, op_unsigned);
    assign div_divisor  = ext33(src2, op_unsigned);

    assign start   = exe_valid & (op_mul | op_div) & ~cancel;
    assign cnt_inc = sat_inc(cnt_q);

`ifdef MD_DIV_ZERO_BYPASS_EN
    assign div_zero_bypass = (src2 == 32'd0);
`else
    assign div_zero_bypass = 1'b0;
`endif

    // Product sign-extension bits and divider padding/upper remainder bits
    // are not needed for 32-bit HI/LO.
    assign unused_bits = ^{mult_p[65:64], div_out_data[79:72], div_out_data[39:32]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                // Start is only looked at here, so an instruction retiring out
                // of DONE can never launch a second time.
                if (start) begin
                    if (op_mul) begin
                        state_d = MUL_WAIT;
                        cnt_d   = '0;
                    end else if (div_zero_bypass) begin
                        state_d = DONE;
                        hi_d    = src1;
                        lo_d    = 32'hFFFF_FFFF;
                    end else begin
                        state_d = DIV_ISSUE;
                    end
                end
            end

            MUL_WAIT: begin
                // The multiplier is pipelined, so abandoning it needs no drain.
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_W'(MULT_LAT - 1)) begin
                        hi_d    = mult_p[63:32];
                        lo_d    = mult_p[31:0];
                        state_d = DONE;
                    end
                end
            end

            DIV_ISSUE: begin
                // The pulse has gone out this cycle; a cancel must still wait
                // for the matching result.
                cnt_d   = '0;
                state_d = cancel ? DRAIN : DIV_WAIT;
            end

            DIV_WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= CNT_W'(DIV_MAX)) begin
                    timeout_d = 1'b1;
                end
                if (cancel) begin
                    // A result arriving with the cancel is the one we would
                    // otherwise drain for, so there is nothing left in flight.
                    state_d = div_out_valid ? IDLE : DRAIN;
                end else if (div_out_valid) begin
                    hi_d    = div_out_data[31:0];
                    lo_d    = div_out_data[71:40];
                    state_d = DONE;
                end
            end

            DONE: begin
                if (cancel || next_allow) begin
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                if (div_out_valid) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            timeout_q <= timeout_d;
        end
    end

    assign md_over      = (state_q == DONE);
    assign md_busy      = (state_q != IDLE);
    assign div_in_valid = (state_q == DIV_ISSUE);
    assign hi_result    = hi_q;
    assign lo_result    = lo_q;
    assign div_timeout  = timeout_q;

endmodule

// File: tb/tb_md_ctrl.sv
`timescale 1ns/1ps
module tb_md_ctrl;

    localparam int MULT_LAT = 1;
    localparam int DIV_MAX  = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_valid, op_mul, op_div, op_unsigned;
    logic [31:0] src1, src2;
    logic        cancel, next_allow;
    logic [32:0] mult_a, mult_b, div_dividend, div_divisor;
    logic [65:0] mult_p;
    logic        div_in_valid, div_out_valid;
    logic [79:0] div_out_data;
    logic        md_over, md_busy;
    logic [31:0] hi_result, lo_result;
    logic        div_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    md_ctrl #(.MULT_LAT(MULT_LAT), .DIV_MAX(DIV_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .exe_valid    (exe_valid),
        .op_mul       (op_mul),
        .op_div       (op_div),
        .op_unsigned  (op_unsigned),
        .src1         (src1),
        .src2         (src2),
        .cancel       (cancel),
        .next_allow   (next_allow),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_p       (mult_p),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_in_valid (div_in_valid),
        .div_out_valid(div_out_valid),
        .div_out_data (div_out_data),
        .md_over      (md_over),
        .md_busy      (md_busy),
        .hi_result    (hi_result),
        .lo_result    (lo_result),
        .div_timeout  (div_timeout)
    );

    // Multiplier IP model: signed 33x33 product, one cycle of latency.
    logic signed [65:0] ma_ext, mb_ext;
    assign ma_ext = $signed(mult_a);
    assign mb_ext = $signed(mult_b);
    always @(posedge clk) mult_p <= ma_ext * mb_ext;

    // Divider IP model: answers div_lat cycles after the input pulse with
    // {pad, quotient[32:0], pad, remainder[32:0]}; div_mute keeps it silent.
    logic signed [32:0] m_dd, m_dv, m_q, m_r;
    logic dv_model = 1'b0;
    logic dv_stray = 1'b0;
    int   div_timer  = 0;
    int   div_pulses = 0;
    int   div_lat    = 20;
    bit   div_mute   = 1'b0;

    always @(posedge clk) begin
        dv_model <= 1'b0;
        if (div_in_valid) begin
            div_pulses <= div_pulses + 1;
            m_dd       <= div_dividend;
            m_dv       <= div_divisor;
            div_timer  <= div_lat - 1;
        end else if (div_timer > 0) begin
            div_timer <= div_timer - 1;
            if (div_timer == 1 && !div_mute) dv_model <= 1'b1;
        end
    end

    assign m_q           = (m_dv == 0) ? 33'sd0 : m_dd / m_dv;
    assign m_r           = (m_dv == 0) ? 33'sd0 : m_dd % m_dv;
    assign div_out_valid = dv_model | dv_stray;
    assign div_out_data  = {7'b0, m_q, 7'b0, m_r};

    typedef struct {
        logic        uns;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [32:0] ea;
        logic [32:0] eb;
    } ext_vec_t;

    ext_vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exe_valid   = 1'b0;
        op_mul      = 1'b0;
        op_div      = 1'b0;
        op_unsigned = 1'b0;
        src1        = 32'd0;
        src2        = 32'd0;
        cancel      = 1'b0;
        next_allow  = 1'b0;
    endtask

    task automatic wait_over(input int max_cyc, output int n);
        n = 0;
        while (md_over !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " md_over"},      md_over, 0);
        chk({tag, " md_busy"},      md_busy, 0);
        chk({tag, " div_in_valid"}, div_in_valid, 0);
        chk({tag, " hi"},           hi_result, 0);
        chk({tag, " lo"},           lo_result, 0);
        chk({tag, " div_timeout"},  div_timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int bad;
        int p0;

        vecs[0] = '{1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 33'h1_8000_0000, 33'h0_7FFF_FFFF};
        vecs[1] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33'h0_8000_0000, 33'h0_FFFF_FFFF};
        vecs[2] = '{1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 33'h1_FFFF_FFFE, 33'h0_0000_0003};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 33'h0_0000_0000, 33'h0_0000_0001};

        // Reset state
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Operand extension table
        for (int i = 0; i < 4; i++) begin
            op_unsigned = vecs[i].uns;
            src1        = vecs[i].s1;
            src2        = vecs[i].s2;
            #1;
            chk($sformatf("ext%0d mult_a", i),       mult_a,       vecs[i].ea);
            chk($sformatf("ext%0d mult_b", i),       mult_b,       vecs[i].eb);
            chk($sformatf("ext%0d div_dividend", i), div_dividend, vecs[i].ea);
            chk($sformatf("ext%0d div_divisor", i),  div_divisor,  vecs[i].eb);
        end
        idle_inputs();
        tick();

        // Signed multiply -2 * 3
        exe_valid = 1'b1; op_mul = 1'b1; src1 = 32'hFFFF_FFFE; src2 = 32'd3;
        chk("mul idle at start", md_busy, 0);
        tick();
        chk("mul busy", md_busy, 1);
        chk("mul over early", md_over, 0);
        tick();
        chk("mul over", md_over, 1);
        chk("mul hi", hi_result, 32'hFFFF_FFFF);
        chk("mul lo", lo_result, 32'hFFFF_FFFA);
        next_allow = 1'b1; exe_valid = 1'b0; op_mul = 1'b0;
        tick();
        chk("mul retire over", md_over, 0);
        chk("mul retire busy", md_busy, 0);
        next_allow = 1'b0;

        // Cancel during MUL_WAIT: nothing latched
        exe_valid = 1'b1; op_mul = 1'b1; src1 = 32'd3; src2 = 32'd3;
        tick();
        cancel = 1'b1; exe_valid = 1'b0;
        tick();
        chk("mulcancel busy", md_busy, 0);
        chk("mulcancel over", md_over, 0);
        chk("mulcancel hi", hi_result, 32'hFFFF_FFFF);
        chk("mulcancel lo", lo_result, 32'hFFFF_FFFA);
        idle_inputs();
        tick();

        // Signed divide -7 / 2, divider answers 20 cycles after the pulse
        div_lat = 20;
        p0 = div_pulses;
        exe_valid = 1'b1; op_div = 1'b1; src1 = 32'hFFFF_FFF9; src2 = 32'd2;
        tick();
        chk("div issue pulse", div_in_valid, 1);
        tick();
        chk("div pulse one cycle", div_in_valid, 0);
        wait_over(60, n);
        chk("div start-to-over cycles", 2 + n, 22);
        chk("div hi", hi_result, 32'hFFFF_FFFF);
        chk("div lo", lo_result, 32'hFFFF_FFFD);
        chk("div pulse count", div_pulses - p0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("div hold over c%0d", i), md_over, 1);
        end
        chk("div hold lo", lo_result, 32'hFFFF_FFFD);
        next_allow = 1'b1; exe_valid = 1'b0; op_div = 1'b0;
        tick();
        chk("div release over", md_over, 0);
        chk("div release busy", md_busy, 0);
        next_allow = 1'b0;

        // Cancel mid-divide, a mul waits behind the drain
        p0 = div_pulses;
        exe_valid = 1'b1; op_div = 1'b1; op_unsigned = 1'b1; src1 = 32'd100; src2 = 32'd7;
        tick();
        chk("drain issue pulse", div_in_valid, 1);
        repeat (5) tick();
        cancel = 1'b1; exe_valid = 1'b0; op_div = 1'b0;
        tick();
        chk("drain busy", md_busy, 1);
        chk("drain over", md_over, 0);
        cancel = 1'b0; exe_valid = 1'b1; op_mul = 1'b1; op_unsigned = 1'b0;
        src1 = 32'd6; src2 = 32'd7;
        bad = 0; n = 0;
        while (div_out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (md_busy !== 1'b1 || md_over !== 1'b0) bad++;
        end
        chk("drain wait cycles", n, 14);
        chk("drain held busy", bad, 0);
        tick();
        chk("drain exit idle", md_busy, 0);
        chk("drain hi kept", hi_result, 32'hFFFF_FFFF);
        chk("drain lo kept", lo_result, 32'hFFFF_FFFD);
        tick();
        chk("mul after drain busy", md_busy, 1);
        tick();
        chk("b2b mul over", md_over, 1);
        chk("b2b mul hi", hi_result, 32'd0);
        chk("b2b mul lo", lo_result, 32'd42);
        chk("drain pulse count", div_pulses - p0, 1);

        // Back-to-back: retiring mul stays on the inputs while DONE exits
        next_allow = 1'b1;
        tick();
        chk("b2b no relaunch busy", md_busy, 0);
        next_allow = 1'b0; op_mul = 1'b0; op_div = 1'b1; op_unsigned = 1'b1;
        src1 = 32'd100; src2 = 32'd7;
        p0 = div_pulses;
        chk("b2b no pulse in idle", div_in_valid, 0);
        tick();
        chk("b2b div pulse", div_in_valid, 1);
        tick();
        wait_over(60, n);
        chk("b2b div wait cycles", n, 20);
        chk("b2b div hi", hi_result, 32'd2);
        chk("b2b div lo", lo_result, 32'd14);
        chk("b2b pulse count", div_pulses - p0, 1);
        next_allow = 1'b1; exe_valid = 1'b0; op_div = 1'b0;
        tick();
        chk("b2b release over", md_over, 0);
        idle_inputs();

        // Cancel in DIV_WAIT in the same cycle the result arrives
        div_lat = 4;
        exe_valid = 1'b1; op_div = 1'b1; src1 = 32'd9; src2 = 32'd2;
        tick();
        repeat (4) tick();
        chk("late cancel result present", div_out_valid, 1);
        cancel = 1'b1; exe_valid = 1'b0; op_div = 1'b0;
        tick();
        chk("late cancel idle", md_busy, 0);
        chk("late cancel over", md_over, 0);
        chk("late cancel hi kept", hi_result, 32'd2);
        chk("late cancel lo kept", lo_result, 32'd14);
        idle_inputs();
        tick();

        // Watchdog: divider stays silent
        div_mute = 1'b1; div_lat = 20;
        exe_valid = 1'b1; op_div = 1'b1; src1 = 32'd1; src2 = 32'd1;
        tick();
        tick();
        repeat (39) tick();
        chk("watchdog not yet", div_timeout, 0);
        tick();
        chk("watchdog set", div_timeout, 1);
        repeat (10) tick();
        chk("watchdog sticky", div_timeout, 1);
        chk("watchdog busy", md_busy, 1);
        chk("watchdog over", md_over, 0);
        reset = 1'b1; exe_valid = 1'b0; op_div = 1'b0;
        tick();
        chk_all_zero("midop reset");
        reset = 1'b0; div_mute = 1'b0;
        tick();

        // Divider tvalid arriving in IDLE is ignored
        dv_stray = 1'b1;
        tick();
        dv_stray = 1'b0;
        tick();
        chk("stray valid busy", md_busy, 0);
        chk("stray valid over", md_over, 0);
        chk("stray valid lo", lo_result, 32'd0);

`ifdef MD_DIV_ZERO_BYPASS_EN
        // Divide by zero bypasses the divider
        p0 = div_pulses;
        exe_valid = 1'b1; op_div = 1'b1; op_unsigned = 1'b1; src1 = 32'd5; src2 = 32'd0;
        tick();
        chk("bypass over", md_over, 1);
        chk("bypass hi", hi_result, 32'd5);
        chk("bypass lo", lo_result, 32'hFFFF_FFFF);
        chk("bypass no pulse now", div_in_valid, 0);
        chk("bypass pulse count", div_pulses - p0, 0);
        next_allow = 1'b1; exe_valid = 1'b0; op_div = 1'b0;
        tick();
        chk("bypass release", md_over, 0);
        idle_inputs();
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
